// File: rtl/fifo_pkg.sv
// Shared sizing helpers and default thresholds for the multi-channel sync FIFO.
package fifo_pkg;

    localparam int DEF_NCH       = 4;
    localparam int DEF_AEMPTY_TH = 1;

    function automatic int depth_of(input int asize);
        return 1 << asize;
    endfunction

    // One extra bit so that a full FIFO (count == DEPTH) is distinct from empty.
    function automatic int cnt_w(input int asize);
        return asize + 1;
    endfunction

    function automatic int def_afull_th(input int asize);
        return (1 << asize) - 2;
    endfunction

endpackage

// File: rtl/fifo_ch.sv
// Single-channel synchronous FIFO, first-word-fall-through, with level flags
// and sticky overflow/underflow error bits cleared by flush.
module fifo_ch
    import fifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ASIZE     = 2,
    parameter int AFULL_TH  = def_afull_th(ASIZE),
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    input  logic             flush,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             rempty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   count,
    output logic             ovf,
    output logic             udf
);

    localparam int DEPTH = depth_of(ASIZE);
    localparam int CW    = cnt_w(ASIZE);

    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             push_acc, pop_acc;
    logic [DSIZE-1:0] mem_q [0:DEPTH-1];

    // A pop on a full FIFO frees the slot the same-cycle push writes into.
    always_comb begin
        pop_acc  = rinc && !flush && (count_q != '0);
        push_acc = winc && !flush && ((count_q != CW'(DEPTH)) || pop_acc);
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_acc) wptr_d = wptr_q + 1'b1;
            if (pop_acc)  rptr_d = rptr_q + 1'b1;
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (winc && !push_acc) ovf_d = 1'b1;
            if (rinc && !pop_acc)  udf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // NOTE: storage has no reset; stale words are unreachable once pointers/count clear.
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wptr_q] <= wdata;
    end

    assign rdata  = mem_q[rptr_q];
    assign count  = count_q;
    assign wfull  = (count_q == CW'(DEPTH));
    assign rempty = (count_q == '0);
    assign afull  = (int'(count_q) >= AFULL_TH);
    assign aempty = (int'(count_q) <= AEMPTY_TH);
    assign ovf    = ovf_q;
    assign udf    = udf_q;

endmodule

// File: rtl/fifo_mc_sync.sv
// NCH independent synchronous FIFOs sharing one clock and reset; each channel
// owns its slice of the packed data/status buses.
`ifndef DATA_WIDTH_BUFF_SO_SEG
`define DATA_WIDTH_BUFF_SO_SEG 8
`endif
`ifndef BITS_SLOW_BLK_BUFF_ADDR
`define BITS_SLOW_BLK_BUFF_ADDR 2
`endif

module fifo_mc_sync
    import fifo_pkg::*;
#(
    parameter int DSIZE     = `DATA_WIDTH_BUFF_SO_SEG,
    parameter int ASIZE     = `BITS_SLOW_BLK_BUFF_ADDR,
    parameter int NCH       = DEF_NCH,
    parameter int AFULL_TH  = def_afull_th(ASIZE),
    parameter int AEMPTY_TH = DEF_AEMPTY_TH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH*DSIZE-1:0]     wdata,
    input  logic [NCH-1:0]           winc,
    input  logic [NCH-1:0]           rinc,
    input  logic [NCH-1:0]           flush,
    output logic [NCH*DSIZE-1:0]     rdata,
    output logic [NCH-1:0]           wfull,
    output logic [NCH-1:0]           rempty,
    output logic [NCH-1:0]           afull,
    output logic [NCH-1:0]           aempty,
    output logic [NCH*(ASIZE+1)-1:0] count,
    output logic [NCH-1:0]           ovf,
    output logic [NCH-1:0]           udf
);

    localparam int CW = cnt_w(ASIZE);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        fifo_ch #(
            .DSIZE    (DSIZE),
            .ASIZE    (ASIZE),
            .AFULL_TH (AFULL_TH),
            .AEMPTY_TH(AEMPTY_TH)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .wdata (wdata[c*DSIZE +: DSIZE]),
            .winc  (winc[c]),
            .rinc  (rinc[c]),
            .flush (flush[c]),
            .rdata (rdata[c*DSIZE +: DSIZE]),
            .wfull (wfull[c]),
            .rempty(rempty[c]),
            .afull (afull[c]),
            .aempty(aempty[c]),
            .count (count[c*CW +: CW]),
            .ovf   (ovf[c]),
            .udf   (udf[c])
        );
    end

endmodule

// File: tb/tb_fifo_mc_sync.sv
// Randomized and directed bench for fifo_mc_sync against a queue-based model.
module tb_fifo_mc_sync;

    localparam int DSIZE = 8;
    localparam int ASIZE = 2;
    localparam int NCH   = 2;
    localparam int DEPTH = 4;
    localparam int CW    = ASIZE + 1;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*DSIZE-1:0] wdata;
    logic [NCH-1:0]       winc, rinc, flush;
    logic [NCH*DSIZE-1:0] rdata;
    logic [NCH-1:0]       wfull, rempty, afull, aempty, ovf, udf;
    logic [NCH*CW-1:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq [NCH][$];
    logic       m_ovf [NCH];
    logic       m_udf [NCH];

    fifo_mc_sync #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .NCH(NCH), .AFULL_TH(3), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
        .flush(flush), .rdata(rdata), .wfull(wfull), .rempty(rempty),
        .afull(afull), .aempty(aempty), .count(count), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    function automatic int get_cnt(input int c);
        return int'(count[c*CW +: CW]);
    endfunction

    function automatic logic [7:0] get_rd(input int c);
        return rdata[c*DSIZE +: DSIZE];
    endfunction

    function automatic logic [5:0] get_flags(input int c);
        return {wfull[c], rempty[c], afull[c], aempty[c], ovf[c], udf[c]};
    endfunction

    function automatic logic [5:0] exp_flags(input int c);
        int n;
        n = mq[c].size();
        return {n == DEPTH, n == 0, n >= 3, n <= 1, m_ovf[c], m_udf[c]};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            mq[c].delete();
            m_ovf[c] = 1'b0;
            m_udf[c] = 1'b0;
        end
    endtask

    // Behavioural rules: a pop frees space for a same-cycle push; flush wins.
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            bit pop, push;
            if (flush[c]) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end else begin
                pop  = rinc[c] && mq[c].size() > 0;
                push = winc[c] && (mq[c].size() < DEPTH || pop);
                if (rinc[c] && !pop)  m_udf[c] = 1'b1;
                if (winc[c] && !push) m_ovf[c] = 1'b1;
                if (pop)  void'(mq[c].pop_front());
                if (push) mq[c].push_back(wdata[c*DSIZE +: DSIZE]);
            end
        end
    endtask

    task automatic cycle(input logic [1:0] w, input logic [1:0] r,
                         input logic [1:0] f, input logic [15:0] d);
        winc = w; rinc = r; flush = f; wdata = d;
        @(posedge clk);
        model_step();
        #1;
        winc = '0; rinc = '0; flush = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; winc = '0; rinc = '0; flush = '0; wdata = '0;
        model_clear();
        #1;
        n_checks++;
        if (count !== '0 || {wfull, afull, ovf, udf} !== '0 || rempty !== 2'b11 || aempty !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_state: got count=%h wf=%b re=%b af=%b ae=%b ovf=%b udf=%b expected count=0 re=11 ae=11 others 0",
                     count, wfull, rempty, afull, aempty, ovf, udf);
        end
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            cycle(2'b01, 2'b00, 2'b00, {8'h00, vals[i]});
            n_checks++;
            if (get_cnt(0) !== i + 1 || afull[0] !== (i >= 2) || wfull[0] !== (i == 3)) begin
                n_fail++;
                $display("FAIL fill_push%0d: got count=%0d af=%b wf=%b expected count=%0d af=%b wf=%b",
                         i, get_cnt(0), afull[0], wfull[0], i + 1, i >= 2, i == 3);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (get_rd(0) !== vals[i]) begin
                n_fail++;
                $display("FAIL drain_head%0d: got %h expected %h", i, get_rd(0), vals[i]);
            end
            cycle(2'b00, 2'b01, 2'b00, '0);
        end
        n_checks++;
        if (rempty[0] !== 1'b1 || get_cnt(0) !== 0) begin
            n_fail++;
            $display("FAIL drain_empty: got re=%b count=%0d expected re=1 count=0", rempty[0], get_cnt(0));
        end
    endtask

    task automatic test_empty_pop_push();
        cycle(2'b10, 2'b10, 2'b00, 16'hA500);
        n_checks++;
        if (udf[1] !== 1'b1 || get_cnt(1) !== 1 || get_rd(1) !== 8'hA5 || get_cnt(0) !== 0 || udf[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_pop_push: got udf=%b cnt1=%0d rd1=%h cnt0=%0d expected udf=10 cnt1=1 rd1=a5 cnt0=0",
                     udf, get_cnt(1), get_rd(1), get_cnt(0));
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 1; i <= 4; i++) cycle(2'b01, 2'b00, 2'b00, 16'(i * 8'h11));
        cycle(2'b01, 2'b01, 2'b00, 16'h0055);
        n_checks++;
        if (get_cnt(0) !== 4 || ovf[0] !== 1'b0 || get_rd(0) !== 8'h22) begin
            n_fail++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b head=%h expected count=4 ovf=0 head=22",
                     get_cnt(0), ovf[0], get_rd(0));
        end
        cycle(2'b01, 2'b00, 2'b00, 16'h0066);
        n_checks++;
        if (get_cnt(0) !== 4 || ovf[0] !== 1'b1 || get_rd(0) !== 8'h22) begin
            n_fail++;
            $display("FAIL full_push_ovf: got count=%0d ovf=%b head=%h expected count=4 ovf=1 head=22",
                     get_cnt(0), ovf[0], get_rd(0));
        end
        // Order after the simultaneous push/pop: 22,33,44,55.
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (get_rd(0) !== mq[0][0] || mq[0][0] !== 8'(8'h22 + i * 8'h11)) begin
                n_fail++;
                $display("FAIL full_order%0d: got %h expected %h", i, get_rd(0), 8'(8'h22 + i * 8'h11));
            end
            if (i == 0) cycle(2'b00, 2'b01, 2'b00, '0);
            else i = 4;
        end
    endtask

    task automatic test_flush();
        n_checks++;
        if (get_cnt(0) !== 3 || ovf[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got count=%0d ovf=%b expected count=3 ovf=1", get_cnt(0), ovf[0]);
        end
        cycle(2'b01, 2'b00, 2'b01, 16'h0077);
        n_checks++;
        if (get_cnt(0) !== 0 || ovf[0] !== 1'b0 || rempty[0] !== 1'b1 || get_cnt(1) !== 1 || udf[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush: got cnt0=%0d ovf0=%b re0=%b cnt1=%0d udf1=%b expected 0 0 1 1 1",
                     get_cnt(0), ovf[0], rempty[0], get_cnt(1), udf[1]);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 6; i++) begin
            logic [7:0] v;
            v = 8'(8'hC0 + i);
            cycle(2'b01, 2'b00, 2'b00, {8'h00, v});
            n_checks++;
            if (get_rd(0) !== v || get_cnt(0) !== 1) begin
                n_fail++;
                $display("FAIL wrap_push%0d: got rd=%h count=%0d expected rd=%h count=1", i, get_rd(0), get_cnt(0), v);
            end
            cycle(2'b00, 2'b01, 2'b00, '0);
        end
        n_checks++;
        if (get_cnt(0) !== 0 || get_cnt(1) !== 1 || get_rd(1) !== 8'hA5) begin
            n_fail++;
            $display("FAIL wrap_end: got cnt0=%0d cnt1=%0d rd1=%h expected 0 1 a5", get_cnt(0), get_cnt(1), get_rd(1));
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [1:0] f;
            f[0] = ($urandom_range(0, 31) == 0);
            f[1] = ($urandom_range(0, 31) == 0);
            cycle(2'($urandom), 2'($urandom), f, 16'($urandom));
            for (int c = 0; c < NCH; c++) begin
                n_checks++;
                if (get_cnt(c) !== mq[c].size() || get_flags(c) !== exp_flags(c)) begin
                    n_fail++;
                    $display("FAIL rand_state cyc%0d ch%0d: got count=%0d flags=%b expected count=%0d flags=%b",
                             n, c, get_cnt(c), get_flags(c), mq[c].size(), exp_flags(c));
                end
                if (mq[c].size() > 0) begin
                    n_checks++;
                    if (get_rd(c) !== mq[c][0]) begin
                        n_fail++;
                        $display("FAIL rand_head cyc%0d ch%0d: got %h expected %h", n, c, get_rd(c), mq[c][0]);
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) cycle(2'b11, 2'b00, 2'b00, 16'h1234);
        cycle(2'b00, 2'b01, 2'b00, '0);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (count !== '0 || {wfull, afull, ovf, udf} !== '0 || rempty !== 2'b11 || aempty !== 2'b11) begin
            n_fail++;
            $display("FAIL async_reset: got count=%h wf=%b re=%b af=%b ae=%b ovf=%b udf=%b expected count=0 re=11 ae=11 others 0",
                     count, wfull, rempty, afull, aempty, ovf, udf);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(2'b01, 2'b00, 2'b00, 16'h005A);
        n_checks++;
        if (get_rd(0) !== 8'h5A || get_cnt(0) !== 1 || get_cnt(1) !== 0) begin
            n_fail++;
            $display("FAIL post_reset_push: got rd=%h cnt0=%0d cnt1=%0d expected 5a 1 0", get_rd(0), get_cnt(0), get_cnt(1));
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_empty_pop_push();
        test_full_push_pop();
        test_flush();
        test_wrap();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_mc_sync.md
FIFO_MC_SYNC -- requirements
Module: fifo_mc_sync

Interface
REQ-001 SHALL have parameter DSIZE, default `DATA_WIDTH_BUFF_SO_SEG, data word width per channel.
REQ-002 SHALL have parameter ASIZE, default `BITS_SLOW_BLK_BUFF_ADDR, address bits; DEPTH = 2**ASIZE.
REQ-003 SHALL have parameter NCH, default 4, number of independent channels (>=1).
REQ-004 SHALL have parameter AFULL_TH, default DEPTH-2, almost-full threshold in entries.
REQ-005 SHALL have parameter AEMPTY_TH, default 1, almost-empty threshold in entries.
REQ-006 SHALL have a single clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 wdata  input  NCH*DSIZE  write data; channel c in slice [c*DSIZE +: DSIZE].
REQ-010 winc  input  NCH  per-channel push request.
REQ-011 rinc  input  NCH  per-channel pop request.
REQ-012 flush  input  NCH  per-channel synchronous clear.
REQ-013 rdata  output  NCH*DSIZE  head entry per channel (first-word-fall-through).
REQ-014 wfull, rempty, afull, aempty  output  NCH each  per-channel status flags.
REQ-015 count  output  NCH*(ASIZE+1)  per-channel occupancy, 0..DEPTH.
REQ-016 ovf, udf  output  NCH each  sticky overflow/underflow error flags.

Function
REQ-017 Channels SHALL be fully independent; no event on channel c SHALL affect channel d != c.
REQ-018 Push SHALL be accepted when winc=1, flush=0, and (count<DEPTH or pop accepted same cycle); write at wptr, wptr+1 mod DEPTH.
REQ-019 Pop SHALL be accepted when rinc=1, flush=0, count>0; rptr+1 mod DEPTH; push same cycle does not enable pop from empty.
REQ-020 count next = count + push_acc - pop_acc; simultaneous accepted push+pop leaves count unchanged, including at full.
REQ-021 rdata SHALL equal mem[rptr] combinationally; valid when rempty=0; value undefined-but-stable when empty.
REQ-022 Push-to-visible latency SHALL be 1 cycle: data pushed at edge N appears on rdata with rempty=0 after edge N.
REQ-023 wfull = (count==DEPTH); rempty = (count==0); both derived from registered count, no comb path from winc/rinc.
REQ-024 afull = (count>=AFULL_TH); aempty = (count<=AEMPTY_TH).
REQ-025 ovf[c] SHALL set on edge where winc=1 is rejected due to full; udf[c] on rinc=1 rejected due to empty; both hold until flush[c] or reset.
REQ-026 flush[c]=1 SHALL on next edge zero rptr, wptr, count, ovf, udf of channel c and take priority over push/pop that cycle.
REQ-027 Pointers SHALL wrap modulo DEPTH; ASIZE+1-bit count disambiguates full vs empty.
REQ-028 Memory contents SHALL not be reset or cleared by flush.

Reset
REQ-029 On rst_n=0, immediately: pointers=0, count=0, rempty=1, aempty=1, wfull=0, afull=0 (if AFULL_TH>0), ovf=0, udf=0.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; first push after release behaves as on an empty FIFO.
REQ-031 No push/pop SHALL be accepted on the edge where rst_n is low.

Structure
REQ-032 Shared package fifo_pkg SHALL hold count/pointer width helper functions and default threshold constants.
REQ-033 One sub-module fifo_ch (single-channel sync FIFO with flags/errors) SHALL be instantiated NCH times via generate.
REQ-034 Storage SHALL be a per-channel register array mem[0:DEPTH-1], write on push_acc only.

Verification (DSIZE=8, ASIZE=2, NCH=2, AFULL_TH=3, AEMPTY_TH=1)
REQ-035 Push 0x11,0x22,0x33,0x44 on ch0 -> count 1..4, afull at 3, wfull at 4; pops return 0x11..0x44 in order, rempty after 4th.
REQ-036 Full ch0, winc=1,rinc=1 -> 0x11 popped, new word stored, count stays 4, ovf=0; winc alone when full -> ovf[0]=1, count 4.
REQ-037 Empty ch1, rinc=1 and winc=1 with 0xA5 -> udf[1]=1, count 1, rdata ch1=0xA5 next cycle.
REQ-038 6 push/pop pairs across wrap on ch0 -> data order preserved, count returns 0; ch1 untouched.
REQ-039 ch0 count=3, ovf=1, flush[0]=1 with winc=1 -> count 0, ovf 0, rempty 1; ch1 count unchanged.
REQ-040 rst_n low mid-stream, async between edges -> all flags/counts at reset values immediately; post-release push 0x5A read back.
